int_return_stack: RTL and testbench

- PC-side consumer of the interrupt manager's outputs (`dir`, `s_interrup`) and of the return-from-interrupt signal `fin`.
- Selects the next PC every cycle: sequential/branch PC, interrupt vector, or saved return address.
- Keeps return addresses in a small LIFO so interrupts can nest and tail-chain.
- Sits between the interrupt manager and the PC register of the monocycle CPU.

---
 rtl/int_return_stack.sv | 108 ++++++++++
 tb/tb_int_return_stack.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/int_return_stack.sv
//------------------------------------------------------------------------------
// int_return_stack
// Next-PC selector with a return-address LIFO for nested and tail-chained ISRs.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module int_return_stack #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4,
    parameter int LVL_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_sig,
    input  logic [ADDR_W-1:0] dir,
    input  logic              s_interrup,
    input  logic              fin,
    output logic [ADDR_W-1:0] pc_next,
    output logic              int_ack,
    output logic [LVL_W-1:0]  nivel,
    output logic              ocupado,
    output logic              ovf,
    output logic              udf
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] r_stack [DEPTH];
    logic [LVL_W-1:0]  r_nivel;
    logic              r_ovf;
    logic              r_udf;

    logic              w_empty;
    logic              w_full;
    logic [LVL_W-1:0]  w_nivel_m1;
    logic [IDX_W-1:0]  w_push_idx;
    logic [IDX_W-1:0]  w_top_idx;
    logic [ADDR_W-1:0] w_top;
    logic              w_push;
    logic              w_pop;
    logic              w_set_ovf;
    logic              w_set_udf;

    assign w_empty    = (r_nivel == '0);
    assign w_full     = (r_nivel == LVL_W'(DEPTH));
    assign w_nivel_m1 = r_nivel - LVL_W'(1);
    // Both indices are only used when they fall inside 0..DEPTH-1.
    assign w_push_idx = IDX_W'(r_nivel);
    assign w_top_idx  = IDX_W'(w_nivel_m1);
    assign w_top      = r_stack[w_top_idx];

    always_comb begin
        pc_next   = pc_sig;
        int_ack   = 1'b0;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_set_ovf = 1'b0;
        w_set_udf = 1'b0;
        if (reset) begin
            pc_next = '0;
        end else if (s_interrup && fin && !w_empty) begin
            // Tail-chain: the new ISR inherits the pending return address.
            pc_next = dir;
            int_ack = 1'b1;
        end else if (s_interrup && !w_full) begin
            pc_next   = dir;
            int_ack   = 1'b1;
            w_push    = 1'b1;
            w_set_udf = fin;
        end else if (s_interrup) begin
            w_set_ovf = 1'b1;
        end else if (fin && !w_empty) begin
            pc_next = w_top;
            w_pop   = 1'b1;
        end else if (fin) begin
            w_set_udf = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_nivel <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_stack[w_push_idx] <= pc_sig;
                r_nivel             <= r_nivel + LVL_W'(1);
            end else if (w_pop) begin
                r_nivel <= w_nivel_m1;
            end
            if (w_set_ovf) r_ovf <= 1'b1;
            if (w_set_udf) r_udf <= 1'b1;
        end
    end

    assign nivel   = r_nivel;
    assign ocupado = !w_empty;
    assign ovf     = r_ovf;
    assign udf     = r_udf;

endmodule

`default_nettype wire

// File: tb/tb_int_return_stack.sv
//------------------------------------------------------------------------------
// tb_int_return_stack
// Directed self-checking bench for the interrupt return-address stack.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_int_return_stack;

    logic       clk;
    logic       reset;
    logic [9:0] pc_sig;
    logic [9:0] dir;
    logic       s_interrup;
    logic       fin;
    logic [9:0] pc_next;
    logic       int_ack;
    logic [2:0] nivel;
    logic       ocupado;
    logic       ovf;
    logic       udf;

    int n_cmp;
    int n_err;

    int_return_stack #(
        .ADDR_W(10),
        .DEPTH (4),
        .LVL_W (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pc_sig    (pc_sig),
        .dir       (dir),
        .s_interrup(s_interrup),
        .fin       (fin),
        .pc_next   (pc_next),
        .int_ack   (int_ack),
        .nivel     (nivel),
        .ocupado   (ocupado),
        .ovf       (ovf),
        .udf       (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; combinational checks follow 2 units later.
    task automatic apply(input logic [9:0] pc, input logic s, input logic [9:0] d, input logic f);
        pc_sig     = pc;
        s_interrup = s;
        dir        = d;
        fin        = f;
        #2;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_comb(input string tag, input logic [9:0] exp_pc, input logic exp_ack);
        chk({tag, ".pc_next"}, 32'(pc_next), 32'(exp_pc));
        chk({tag, ".int_ack"}, 32'(int_ack), 32'(exp_ack));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        apply(10'd123, 1'b1, 10'd5, 1'b1);
        chk_comb("reset_outs", 10'd0, 1'b0);
        tick();
        chk("reset_nivel", 32'(nivel), 0);
        chk("reset_ovf", 32'(ovf), 0);
        chk("reset_udf", 32'(udf), 0);
        reset = 1'b0;

        apply(10'd5, 1'b0, 10'd0, 1'b0);
        chk_comb("idle", 10'd5, 1'b0);
        chk("idle_ocupado", 32'(ocupado), 0);
        tick();

        // Single interrupt and return, with X on dir while idle
        apply(10'd20, 1'b1, 10'd824, 1'b0);
        chk_comb("irq1", 10'd824, 1'b1);
        tick();
        chk("irq1_nivel", 32'(nivel), 1);
        chk("irq1_ocupado", 32'(ocupado), 1);
        apply(10'd21, 1'b0, 10'bx, 1'b0);
        chk_comb("dir_x", 10'd21, 1'b0);
        tick();
        apply(10'd22, 1'b0, 10'd0, 1'b1);
        chk_comb("ret1", 10'd20, 1'b0);
        tick();
        chk("ret1_nivel", 32'(nivel), 0);

        // Nesting
        apply(10'd30, 1'b1, 10'd824, 1'b0);
        chk_comb("nest_a", 10'd824, 1'b1);
        tick();
        apply(10'd830, 1'b1, 10'd874, 1'b0);
        chk_comb("nest_b", 10'd874, 1'b1);
        tick();
        chk("nest_nivel2", 32'(nivel), 2);
        apply(10'd880, 1'b0, 10'd0, 1'b1);
        chk_comb("nest_ret_b", 10'd830, 1'b0);
        tick();
        chk("nest_nivel1", 32'(nivel), 1);
        apply(10'd835, 1'b0, 10'd0, 1'b1);
        chk_comb("nest_ret_a", 10'd30, 1'b0);
        tick();
        chk("nest_nivel0", 32'(nivel), 0);

        // Fill the stack, then a refused request
        for (int i = 1; i <= 4; i++) begin
            apply(10'(100 * i), 1'b1, 10'd500, 1'b0);
            chk_comb("fill", 10'd500, 1'b1);
            tick();
        end
        chk("full_nivel", 32'(nivel), 4);
        chk("full_ovf_clear", 32'(ovf), 0);
        apply(10'd900, 1'b1, 10'd974, 1'b0);
        chk_comb("refused", 10'd900, 1'b0);
        tick();
        chk("refused_nivel", 32'(nivel), 4);
        chk("refused_ovf", 32'(ovf), 1);
        for (int i = 4; i >= 1; i--) begin
            apply(10'd901, 1'b0, 10'd0, 1'b1);
            chk_comb("drain", 10'(100 * i), 1'b0);
            tick();
        end
        chk("drain_nivel", 32'(nivel), 0);
        chk("ovf_sticky", 32'(ovf), 1);

        // Tail-chain
        apply(10'd20, 1'b1, 10'd824, 1'b0);
        chk_comb("tc_accept", 10'd824, 1'b1);
        tick();
        apply(10'd50, 1'b1, 10'd924, 1'b1);
        chk_comb("tc_chain", 10'd924, 1'b1);
        tick();
        chk("tc_nivel", 32'(nivel), 1);
        chk("tc_udf", 32'(udf), 0);
        apply(10'd60, 1'b0, 10'd0, 1'b1);
        chk_comb("tc_ret", 10'd20, 1'b0);
        tick();
        chk("tc_nivel0", 32'(nivel), 0);

        // Underflow
        apply(10'd7, 1'b0, 10'd0, 1'b1);
        chk_comb("udf", 10'd7, 1'b0);
        tick();
        chk("udf_flag", 32'(udf), 1);
        chk("udf_nivel", 32'(nivel), 0);

        // Reset mid-ISR
        apply(10'd40, 1'b1, 10'd600, 1'b0);
        tick();
        apply(10'd41, 1'b1, 10'd610, 1'b0);
        tick();
        chk("pre_rst_nivel", 32'(nivel), 2);
        reset = 1'b1;
        apply(10'd77, 1'b0, 10'd0, 1'b1);
        chk_comb("mid_rst", 10'd0, 1'b0);
        tick();
        chk("rst_nivel", 32'(nivel), 0);
        chk("rst_udf", 32'(udf), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_ocupado", 32'(ocupado), 0);
        reset = 1'b0;
        apply(10'd9, 1'b0, 10'd0, 1'b0);
        chk_comb("post_rst", 10'd9, 1'b0);
        tick();

        // Interrupt plus return with an empty stack: push and flag underflow
        apply(10'd11, 1'b1, 10'd600, 1'b1);
        chk_comb("sf_empty", 10'd600, 1'b1);
        tick();
        chk("sf_nivel", 32'(nivel), 1);
        chk("sf_udf", 32'(udf), 1);
        apply(10'd12, 1'b0, 10'd0, 1'b1);
        chk_comb("sf_ret", 10'd11, 1'b0);
        tick();
        chk("sf_nivel0", 32'(nivel), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
